// File: rtl/control.sv
// Multicycle RV32I control FSM: sequences fetch, decode and execute for the
// datapath, and drives the memory request/byte-enable handshake.
module control (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       br_en,
    input  logic [1:0] mem_address,
    input  logic       mem_resp,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_data_out,
    output logic       pcmux_sel,
    output logic       alumux1_sel,
    output logic [1:0] alumux2_sel,
    output logic [1:0] regfilemux_sel,
    output logic       marmux_sel,
    output logic       cmpmux_sel,
    output logic [2:0] aluop,
    output logic [2:0] cmpop,
    output logic       mem_read,
    output logic       mem_write,
    output logic [3:0] mem_byte_enable
);

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SRA  = 3'd2;
    localparam logic [2:0] CMP_BLT  = 3'd4;
    localparam logic [2:0] CMP_BLTU = 3'd6;

    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_SB   = 3'b000;
    localparam logic [2:0] F3_SH   = 3'b001;

    localparam logic [1:0] ALUMUX2_I = 2'd0;
    localparam logic [1:0] ALUMUX2_U = 2'd1;
    localparam logic [1:0] ALUMUX2_B = 2'd2;
    localparam logic [1:0] ALUMUX2_S = 2'd3;

    localparam logic [1:0] RFMUX_ALU = 2'd0;
    localparam logic [1:0] RFMUX_BR  = 2'd1;
    localparam logic [1:0] RFMUX_U   = 2'd2;
    localparam logic [1:0] RFMUX_MDR = 2'd3;

    typedef enum logic [3:0] {
        FETCH1,
        FETCH2,
        FETCH3,
        DECODE,
        IMM,
        REG,
        LUI,
        AUIPC,
        BR,
        CALC_ADDR,
        LD1,
        LD2,
        ST1,
        ST2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] w_aluop_dec;
    logic [3:0] w_store_be;
    logic       w_is_slt;
    logic       w_unused;

    // Only funct7[5] distinguishes sra from srl; the other bits are don't-care.
    assign w_unused    = ^{funct7[6], funct7[4:0]};
    assign w_aluop_dec = (funct3 == F3_SR && funct7[5]) ? ALU_SRA : funct3;
    assign w_is_slt    = (funct3 == F3_SLT) || (funct3 == F3_SLTU);

    // Store byte lanes: sub-word stores select lanes from the low address bits.
    always_comb begin
        case (funct3)
            F3_SB:   w_store_be = 4'b0001 << mem_address;
            F3_SH:   w_store_be = mem_address[1] ? 4'b1100 : 4'b0011;
            default: w_store_be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH1;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_data_out   = 1'b0;
        pcmux_sel       = 1'b0;
        alumux1_sel     = 1'b0;
        alumux2_sel     = ALUMUX2_I;
        regfilemux_sel  = RFMUX_ALU;
        marmux_sel      = 1'b0;
        cmpmux_sel      = 1'b0;
        aluop           = ALU_ADD;
        cmpop           = 3'd0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'b1111;

        case (r_state)
            FETCH1: begin
                load_mar     = 1'b1;
                w_next_state = FETCH2;
            end
            FETCH2: begin
                mem_read = 1'b1;
                load_mdr = 1'b1;
                if (mem_resp) begin
                    w_next_state = FETCH3;
                end
            end
            FETCH3: begin
                load_ir      = 1'b1;
                w_next_state = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_IMM:   w_next_state = IMM;
                    OP_REG:   w_next_state = REG;
                    OP_LUI:   w_next_state = LUI;
                    OP_AUIPC: w_next_state = AUIPC;
                    OP_BR:    w_next_state = BR;
                    OP_LOAD,
                    OP_STORE: w_next_state = CALC_ADDR;
                    default: begin
                        // Unsupported opcode: step past it to the next word.
                        load_pc      = 1'b1;
                        w_next_state = FETCH1;
                    end
                endcase
            end
            IMM: begin
                load_regfile = 1'b1;
                load_pc      = 1'b1;
                if (w_is_slt) begin
                    cmpmux_sel     = 1'b1;
                    cmpop          = (funct3 == F3_SLT) ? CMP_BLT : CMP_BLTU;
                    regfilemux_sel = RFMUX_BR;
                end else begin
                    aluop = w_aluop_dec;
                end
                w_next_state = FETCH1;
            end
            REG: begin
                // Without an rs2 ALU input only slt/sltu can retire a result.
                load_pc = 1'b1;
                if (w_is_slt) begin
                    load_regfile   = 1'b1;
                    cmpop          = (funct3 == F3_SLT) ? CMP_BLT : CMP_BLTU;
                    regfilemux_sel = RFMUX_BR;
                end else begin
                    aluop = w_aluop_dec;
                end
                w_next_state = FETCH1;
            end
            LUI: begin
                regfilemux_sel = RFMUX_U;
                load_regfile   = 1'b1;
                load_pc        = 1'b1;
                w_next_state   = FETCH1;
            end
            AUIPC: begin
                alumux1_sel  = 1'b1;
                alumux2_sel  = ALUMUX2_U;
                load_regfile = 1'b1;
                load_pc      = 1'b1;
                w_next_state = FETCH1;
            end
            BR: begin
                alumux1_sel  = 1'b1;
                alumux2_sel  = ALUMUX2_B;
                cmpop        = funct3;
                load_pc      = 1'b1;
                pcmux_sel    = br_en;
                w_next_state = FETCH1;
            end
            CALC_ADDR: begin
                marmux_sel = 1'b1;
                load_mar   = 1'b1;
                if (opcode == OP_STORE) begin
                    alumux2_sel   = ALUMUX2_S;
                    load_data_out = 1'b1;
                    w_next_state  = ST1;
                end else begin
                    w_next_state = LD1;
                end
            end
            LD1: begin
                mem_read = 1'b1;
                load_mdr = 1'b1;
                if (mem_resp) begin
                    w_next_state = LD2;
                end
            end
            LD2: begin
                regfilemux_sel = RFMUX_MDR;
                load_regfile   = 1'b1;
                load_pc        = 1'b1;
                w_next_state   = FETCH1;
            end
            ST1: begin
                mem_write       = 1'b1;
                mem_byte_enable = w_store_be;
                if (mem_resp) begin
                    w_next_state = ST2;
                end
            end
            ST2: begin
                load_pc      = 1'b1;
                w_next_state = FETCH1;
            end
            default: begin
                w_next_state = FETCH1;
            end
        endcase
    end

endmodule
